// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: issues single-beat instruction fetches at pc and holds
// the returned word in a one-entry valid/ready register for decode; accepts redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] boot_cnt;
  logic       xfer;
  logic       consume;

  assign xfer    = imem_req && imem_ready;
  assign consume = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      boot_cnt <= (state == BOOT) ? boot_cnt + 4'd1 : 4'd0;
    end
  end

  // Redirects never change the sequencer state, so BOOT keeps counting through them.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    if (boot_cnt == BOOT_LAST) state_next = FETCH;
      FETCH:   if (halt) state_next = HALTED;
      HALTED:  if (!halt) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state == FETCH)
      imem_req = (!instr_valid || instr_ready) && !redirect_valid && !halt;
  end

  // Redirect flushes the output register and outranks both transfer and consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      instr        <= 32'd0;
      instr_pc     <= 32'd0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc          <= {redirect_target[31:2], 2'b00};
        instr_valid <= 1'b0;
        if (redirect_target[1:0] != 2'b00)
          misalign_err <= 1'b1;
      end else if (xfer) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc_plus4;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl: per-cycle inputs with hand-computed expected
// outputs observed just after the falling edge, plus async-reset and boot-redirect sequences.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RDATA_KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        halt = 1'b0;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        halt;
    logic        rv;
    logic [31:0] tgt;
    logic        ir;
    logic        dr;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_iv;
    logic [31:0] exp_ipc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[28];

  // The adder and memory are modelled here: the word at address a is a ^ RDATA_KEY.
  assign pc_plus4   = pc + 32'd4;
  assign imem_rdata = pc ^ RDATA_KEY;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .misalign_err   (misalign_err)
  );

  function automatic vec_t mk(input logic h, input logic rv, input logic [31:0] tgt,
                              input logic ir, input logic dr, input logic req,
                              input logic [31:0] p, input logic iv,
                              input logic [31:0] ipc, input logic mis);
    vec_t v;
    v.halt = h; v.rv = rv; v.tgt = tgt; v.ir = ir; v.dr = dr;
    v.exp_req = req; v.exp_pc = p; v.exp_iv = iv; v.exp_ipc = ipc; v.exp_mis = mis;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp({tag, " imem_req"},     32'(imem_req),     32'(v.exp_req));
    cmp({tag, " pc"},           pc,                v.exp_pc);
    cmp({tag, " instr_valid"},  32'(instr_valid),  32'(v.exp_iv));
    cmp({tag, " instr_pc"},     instr_pc,          v.exp_ipc);
    cmp({tag, " misalign_err"}, 32'(misalign_err), 32'(v.exp_mis));
    if (v.exp_iv) cmp({tag, " instr"}, instr, v.exp_ipc ^ RDATA_KEY);
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    halt            = v.halt;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    imem_ready      = v.ir;
    instr_ready     = v.dr;
    #1;
    checkOutput(tag, v);
  endtask

  initial begin
    //              halt rv tgt            ir dr  req pc             iv ipc            mis
    vecs[0]  = mk(0, 0, 32'h0,         1, 1,  0, 32'h0,         0, 32'h0,         0);
    vecs[1]  = mk(0, 0, 32'h0,         1, 1,  0, 32'h0,         0, 32'h0,         0);
    vecs[2]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h0,         0, 32'h0,         0);
    vecs[3]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h4,         1, 32'h0,         0);
    vecs[4]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h8,         1, 32'h4,         0);
    vecs[5]  = mk(0, 0, 32'h0,         1, 1,  1, 32'hC,         1, 32'h8,         0);
    vecs[6]  = mk(0, 0, 32'h0,         1, 0,  0, 32'h10,        1, 32'hC,         0);
    vecs[7]  = mk(0, 0, 32'h0,         1, 0,  0, 32'h10,        1, 32'hC,         0);
    vecs[8]  = mk(0, 0, 32'h0,         1, 0,  0, 32'h10,        1, 32'hC,         0);
    vecs[9]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h10,        1, 32'hC,         0);
    vecs[10] = mk(0, 0, 32'h0,         0, 1,  1, 32'h14,        1, 32'h10,        0);
    vecs[11] = mk(0, 0, 32'h0,         1, 1,  1, 32'h14,        0, 32'h10,        0);
    vecs[12] = mk(0, 1, 32'h100,       1, 1,  0, 32'h18,        1, 32'h14,        0);
    vecs[13] = mk(0, 0, 32'h0,         1, 1,  1, 32'h100,       0, 32'h14,        0);
    vecs[14] = mk(0, 0, 32'h0,         1, 1,  1, 32'h104,       1, 32'h100,       0);
    vecs[15] = mk(0, 1, 32'h203,       1, 1,  0, 32'h108,       1, 32'h104,       0);
    vecs[16] = mk(0, 0, 32'h0,         1, 1,  1, 32'h200,       0, 32'h104,       1);
    vecs[17] = mk(1, 0, 32'h0,         1, 0,  0, 32'h204,       1, 32'h200,       1);
    vecs[18] = mk(1, 0, 32'h0,         1, 0,  0, 32'h204,       1, 32'h200,       1);
    vecs[19] = mk(1, 0, 32'h0,         1, 1,  0, 32'h204,       1, 32'h200,       1);
    vecs[20] = mk(1, 0, 32'h0,         1, 1,  0, 32'h204,       0, 32'h200,       1);
    vecs[21] = mk(0, 0, 32'h0,         1, 1,  0, 32'h204,       0, 32'h200,       1);
    vecs[22] = mk(0, 0, 32'h0,         1, 1,  1, 32'h204,       0, 32'h200,       1);
    vecs[23] = mk(0, 0, 32'h0,         1, 1,  1, 32'h208,       1, 32'h204,       1);
    vecs[24] = mk(0, 1, 32'hFFFF_FFFC, 1, 1,  0, 32'h20C,       1, 32'h208,       1);
    vecs[25] = mk(0, 0, 32'h0,         1, 1,  1, 32'hFFFF_FFFC, 0, 32'h208,       1);
    vecs[26] = mk(0, 0, 32'h0,         1, 1,  1, 32'h0,         1, 32'hFFFF_FFFC, 1);
    vecs[27] = mk(0, 0, 32'h0,         1, 1,  1, 32'h4,         1, 32'h0,         1);

    $display("[TB] start");
    @(negedge clk);
    #1;
    checkOutput("reset", vecs[0]);
    cmp("reset instr", instr, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("v0", vecs[0]);
    for (int i = 1; i < 28; i++) begin
      @(negedge clk);
      applyStimulus($sformatf("v%0d", i), vecs[i]);
    end

    // Pulse reset between edges while fetching: everything must clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", mk(0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0, 0));
    cmp("async_rst instr", instr, 32'h0);

    // Redirect during BOOT: pc moves but the boot count still expires on schedule.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("boot_rd0", mk(0, 1, 32'h40, 1, 1, 0, 32'h0,  0, 32'h0,  0));
    @(negedge clk);
    applyStimulus("boot_rd1", mk(0, 0, 32'h0,  1, 1, 0, 32'h40, 0, 32'h0,  0));
    @(negedge clk);
    applyStimulus("boot_rd2", mk(0, 0, 32'h0,  1, 1, 1, 32'h40, 0, 32'h0,  0));
    @(negedge clk);
    applyStimulus("boot_rd3", mk(0, 0, 32'h0,  1, 1, 1, 32'h44, 1, 32'h40, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
